// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM with unified-memory handshake and a sticky illegal-opcode flag.
// Optional retirement counter output enabled by defining MULTICYCLE_CTRL_RETIRE_CNT_EN.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        arst,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  mem_2_reg,
  output logic        illegal,
  output logic [3:0]  state
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  ,
  output logic [31:0] retired_cnt
`endif
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC     = 4'd2,
    ALU_WB   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WB   = 4'd6,
    MEM_WR   = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    HALT     = 4'd10
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t state_q, state_d;
  logic   rtype_q, rtype_d;
  logic   illegal_q, illegal_d;

  // R/I distinction is captured in DECODE so EXEC never looks at opcode.
  always_comb begin
    state_d = state_q;
    rtype_d = rtype_q;
    case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        rtype_d = (opcode == OP_R);
        case (opcode)
          OP_R, OP_I:         state_d = EXEC;
          OP_LOAD, OP_STORE:  state_d = MEM_ADDR;
          OP_BRANCH:          state_d = BRANCH;
          OP_JAL:             state_d = JUMP;
          default:            state_d = HALT;
        endcase
      end
      EXEC:     state_d = ALU_WB;
      ALU_WB:   state_d = FETCH;
      MEM_ADDR: begin
        if (opcode == OP_LOAD)       state_d = MEM_RD;
        else if (opcode == OP_STORE) state_d = MEM_WR;
        else                         state_d = HALT;
      end
      MEM_RD:   if (mem_ready) state_d = MEM_WB;
      MEM_WB:   state_d = FETCH;
      MEM_WR:   if (mem_ready) state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JUMP:     state_d = FETCH;
      HALT:     state_d = HALT;
      default:  state_d = HALT;
    endcase
    illegal_d = illegal_q | (state_d == HALT);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= FETCH;
      rtype_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rtype_q   <= rtype_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  logic        retire;
  logic [31:0] retired_q, retired_d;

  always_comb begin
    retire    = (state_d == FETCH) &&
                (state_q inside {ALU_WB, MEM_WB, MEM_WR, BRANCH, JUMP});
    retired_d = retire ? retired_q + 32'd1 : retired_q;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) retired_q <= 32'd0;
    else      retired_q <= retired_d;
  end

  assign retired_cnt = retired_q;
`endif

  // Strobes are held low while arst is high so an in-flight memory access is dropped at once.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    pc_src    = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op    = 2'b00;
    mem_2_reg = 2'b00;
    if (!arst) begin
      case (state_q)
        FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE:   alu_src_b = 2'b10;
        EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = rtype_q ? 2'b00 : 2'b10;
          alu_op    = rtype_q ? 2'b10 : 2'b00;
        end
        ALU_WB:   reg_write = 1'b1;
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        MEM_WB: begin
          reg_write = 1'b1;
          mem_2_reg = 2'b01;
        end
        MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
        end
        BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          pc_src    = 1'b1;
          pc_write  = branch_taken;
        end
        JUMP: begin
          reg_write = 1'b1;
          mem_2_reg = 2'b10;
          pc_src    = 1'b1;
          pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule
